// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock divider / tick generator with a loadable terminal count,
// toggle or pulse output mode, count enable and a registered one-cycle wrap strobe.
module clk_divider_prog #(
  parameter int unsigned      CNT_W        = 21,
  parameter logic [CNT_W-1:0] DEFAULT_DIV  = {CNT_W{1'b1}},
  parameter logic             DEFAULT_MODE = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             mode_val,
  input  logic             div_load,
  output logic             divided_clk,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] cnt
);

  // Load interface: div_load is a single-cycle strobe with no back-pressure;
  // div_val/mode_val are sampled only in cycles where div_load is high.

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             apply_now;
  logic [CNT_W-1:0] new_div;
  logic             new_mode;

  // >= rather than == so a ratio lowered below the live count still wraps.
  assign wrap      = en && (cnt_q >= div_q);
  assign apply_now = wrap || !en;

  // A load in the applying cycle beats any older pending values.
  assign new_div  = div_load ? div_val  : (pend_q ? pend_div_q  : div_q);
  assign new_mode = div_load ? mode_val : (pend_q ? pend_mode_q : mode_q);

  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pend_d      = pend_q;
    out_d       = out_q;
    tick_d      = 1'b0;

    if (apply_now) begin
      div_d  = new_div;
      mode_d = new_mode;
      pend_d = 1'b0;
    end else if (div_load) begin
      pend_div_d  = div_val;
      pend_mode_d = mode_val;
      pend_d      = 1'b1;
    end

    if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      // The mode that takes effect at this wrap already drives the output here.
      out_d  = new_mode ? 1'b1 : ~out_q;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_q) out_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      div_q       <= DEFAULT_DIV;
      mode_q      <= DEFAULT_MODE;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
      pend_q      <= 1'b0;
      out_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      tick_q      <= tick_d;
    end
  end

  assign divided_clk = out_q;
  assign tick        = tick_q;
  assign pending     = pend_q;
  assign cnt         = cnt_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog (CNT_W=4, DEFAULT_DIV=3): directed scenarios plus
// randomized traffic, every cycle compared against a behavioural model.
module tb_clk_divider_prog;

  localparam int unsigned CNT_W = 4;

  logic             clk_in;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             mode_val;
  logic             div_load;
  logic             divided_clk;
  logic             tick;
  logic             pending;
  logic [CNT_W-1:0] cnt;

  clk_divider_prog #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (4'd3),
    .DEFAULT_MODE(1'b0)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .div_val    (div_val),
    .mode_val   (mode_val),
    .div_load   (div_load),
    .divided_clk(divided_clk),
    .tick       (tick),
    .pending    (pending),
    .cnt        (cnt)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // behavioural model: settings waiting for a wrap live in a queue of {mode,div}
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_div;
  logic             m_mode;
  logic             m_out;
  logic             m_tick;
  logic [CNT_W:0]   m_pend[$];

  logic [CNT_W+2:0] exp_q[$];

  task automatic model_reset();
    m_cnt  = '0;
    m_div  = 4'd3;
    m_mode = 1'b0;
    m_out  = 1'b0;
    m_tick = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_stash();
    m_pend.delete();
    m_pend.push_back({mode_val, div_val});
  endtask

  task automatic model_apply();
    if (m_pend.size() > 0) begin
      {m_mode, m_div} = m_pend[$];
      m_pend.delete();
    end
  endtask

  task automatic model_step();
    if (!en) begin
      m_tick = 1'b0;
      if (div_load) model_stash();
      model_apply();
    end else if (m_cnt >= m_div) begin
      if (div_load) model_stash();
      model_apply();
      m_cnt  = '0;
      m_tick = 1'b1;
      m_out  = m_mode ? 1'b1 : !m_out;
    end else begin
      m_cnt  = m_cnt + 1'b1;
      m_tick = 1'b0;
      if (m_mode) m_out = 1'b0;
      if (div_load) model_stash();
    end
  endtask

  // driver: one clock, inputs already set by the caller, outputs checked 1 time unit later
  task automatic step_clk();
    logic [CNT_W+2:0] e;
    @(posedge clk_in);
    if (rst) model_reset();
    else model_step();
    exp_q.push_back({m_out, m_tick, (m_pend.size() > 0), m_cnt});
    #1;
    e = exp_q.pop_front();
    check_val("outs", {25'd0, divided_clk, tick, pending, cnt}, {25'd0, e});
  endtask

  task automatic steer_to(input logic [CNT_W-1:0] target);
    for (int i = 0; i < 40 && m_cnt != target; i++) step_clk();
    check_val("steer", {28'd0, m_cnt}, {28'd0, target});
  endtask

  task automatic count_run(input int n, output int ticks, output int rises, output int highs);
    logic prev;
    prev  = divided_clk;
    ticks = 0;
    rises = 0;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step_clk();
      if (tick) ticks++;
      if (divided_clk && !prev) rises++;
      if (divided_clk) highs++;
      prev = divided_clk;
    end
  endtask

  initial begin
    int ticks, rises, highs;
    rst      = 1'b1;
    en       = 1'b0;
    div_val  = '0;
    mode_val = 1'b0;
    div_load = 1'b0;
    model_reset();
    step_clk();
    step_clk();
    check_val("rst_cnt", {28'd0, cnt}, 0);
    check_val("rst_clk", {31'd0, divided_clk}, 0);
    check_val("rst_tick", {31'd0, tick}, 0);
    check_val("rst_pend", {31'd0, pending}, 0);

    // 1: default ratio 3, toggle
    rst = 1'b0;
    en  = 1'b1;
    count_run(16, ticks, rises, highs);
    check_val("t1_ticks", ticks, 4);
    check_val("t1_rises", rises, 2);

    // 2: load ratio 1 mid-period, applied at the next wrap
    steer_to(4'd1);
    div_load = 1'b1; div_val = 4'd1; mode_val = 1'b0;
    step_clk();
    div_load = 1'b0;
    check_val("t2_pend", {31'd0, pending}, 1);
    step_clk();
    check_val("t2_pend_hold", {31'd0, pending}, 1);
    step_clk();
    check_val("t2_pend_clr", {31'd0, pending}, 0);
    count_run(8, ticks, rises, highs);
    check_val("t2_ticks", ticks, 4);

    // 3: load with a simultaneous wrap goes straight in; pulse mode, ratio 5
    steer_to(4'd1);
    div_load = 1'b1; div_val = 4'd5; mode_val = 1'b1;
    step_clk();
    div_load = 1'b0;
    check_val("t3_pend", {31'd0, pending}, 0);
    check_val("t3_pulse", {31'd0, divided_clk}, 1);
    count_run(12, ticks, rises, highs);
    check_val("t3_highs", highs, 2);
    check_val("t3_ticks", ticks, 2);

    // 4: freeze at cnt=2
    steer_to(4'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_clk();
      check_val("t4_cnt", {28'd0, cnt}, 2);
      check_val("t4_tick", {31'd0, tick}, 0);
    end
    en = 1'b1;
    step_clk();
    check_val("t4_resume", {28'd0, cnt}, 3);

    // 5: ratio 9 toggle, then lower to 2 while cnt=7
    en = 1'b0; div_load = 1'b1; div_val = 4'd9; mode_val = 1'b0;
    step_clk();
    div_load = 1'b0; en = 1'b1;
    steer_to(4'd7);
    en = 1'b0; div_load = 1'b1; div_val = 4'd2;
    step_clk();
    div_load = 1'b0;
    check_val("t5_hold", {28'd0, cnt}, 7);
    check_val("t5_pend", {31'd0, pending}, 0);
    en = 1'b1;
    step_clk();
    check_val("t5_wrap_cnt", {28'd0, cnt}, 0);
    check_val("t5_wrap_tick", {31'd0, tick}, 1);

    // 6: asynchronous reset with a load pending
    step_clk();
    div_load = 1'b1; div_val = 4'd7; mode_val = 1'b1;
    step_clk();
    div_load = 1'b0;
    check_val("t6_pend", {31'd0, pending}, 1);
    #3 rst = 1'b1;
    #1;
    check_val("t6_cnt", {28'd0, cnt}, 0);
    check_val("t6_clk", {31'd0, divided_clk}, 0);
    check_val("t6_tick", {31'd0, tick}, 0);
    check_val("t6_pend_clr", {31'd0, pending}, 0);
    model_reset();
    step_clk();
    step_clk();
    rst = 1'b0;
    count_run(16, ticks, rises, highs);
    check_val("t6_rises", rises, 2);
    check_val("t6_ticks", ticks, 4);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 7) == 0);
      div_val  = CNT_W'($urandom_range(0, 15));
      mode_val = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 199) == 0);
      step_clk();
    end
    rst = 1'b0;
    div_load = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
